// File: rtl/sysid_read_sequencer.sv
// sysid_read_sequencer
// Reads the system-ID word (address 0) and the build-timestamp word (address 1)
// over a minimal Avalon-MM read master. It compares both words with the expected
// values and reports the result. Each read attempt is bounded by a waitrequest
// timeout. A timed-out attempt is retried after a one-cycle gap with avm_read low.
// When the retries for a word run out, the sequence aborts with timeout_err.
//
// Ports
//   clock, reset_n       single rising-edge clock, async active-low reset
//   start                one-cycle request; accepted only in IDLE
//   avm_address/avm_read read master: address 0 = ID, 1 = timestamp
//   avm_readdata         read data, valid when avm_read=1 and waitrequest=0
//   avm_waitrequest      slave stall
//   busy, done           busy outside IDLE; done pulses once at the end
//   id_ok, ts_ok         compare results registered in CHECK
//   timeout_err          retries for a word exhausted
//   id_value, ts_value   last captured words
module sysid_read_sequencer #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1485636471,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, FINISH} state_t;

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);

  state_t      state, state_nxt;
  logic        gap;        // one-cycle read-low slot between retry attempts
  logic [7:0]  tmo_cnt;
  logic [2:0]  retry_cnt;
  logic        rd_state, ack, hit, exhaust;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Outputs are decoded from registered state. Async reset therefore forces
  // them low at once, with no clock edge needed.
  always_comb begin
    state_nxt   = state;
    rd_state    = (state == RD_ID) || (state == RD_TS);
    avm_read    = rd_state && !gap;
    avm_address = (state == RD_TS);
    busy        = (state != IDLE);
    done        = (state == FINISH);
    ack         = avm_read && !avm_waitrequest;
    // The attempt ends on the stalled cycle that brings the count to TIMEOUT_CYCLES.
    hit         = avm_read && avm_waitrequest && (tmo_cnt == TMO_LAST);
    exhaust     = hit && (retry_cnt == RETRY_MAX);
    case (state)
      IDLE:   if (start) state_nxt = RD_ID;
      RD_ID:  if (ack) state_nxt = RD_TS;
              else if (exhaust) state_nxt = FINISH;
      RD_TS:  if (ack) state_nxt = CHECK;
              else if (exhaust) state_nxt = FINISH;
      CHECK:  state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      tmo_cnt     <= '0;
      retry_cnt   <= '0;
      gap         <= 1'b0;
    end else if (state == IDLE && start) begin
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
      retry_cnt   <= '0;
      gap         <= 1'b0;
    end else if (rd_state) begin
      if (gap) begin
        gap <= 1'b0;
      end else if (ack) begin
        tmo_cnt <= '0;
        if (state == RD_ID) begin
          id_value  <= avm_readdata;
          retry_cnt <= '0;           // the timestamp word gets its own retry budget
        end else begin
          ts_value  <= avm_readdata;
        end
      end else if (hit) begin
        tmo_cnt <= '0;
        if (exhaust) timeout_err <= 1'b1;   // abort; ok flags and ts_value stay as they are
        else begin
          retry_cnt <= retry_cnt + 3'd1;
          gap       <= 1'b1;
        end
      end else begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end else if (state == CHECK) begin
      id_ok <= (id_value == EXPECTED_ID);
      ts_ok <= (ts_value == EXPECTED_TS);
    end
  end

endmodule

// File: tb/tb_sysid_read_sequencer.sv
module tb_sysid_read_sequencer;
  localparam logic [31:0] T = 32'd1485636471;

  logic        clock = 1'b0;
  logic        reset_n, start;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;

  always #5 clock = ~clock;

  sysid_read_sequencer #(.EXPECTED_ID(32'h0), .EXPECTED_TS(T),
                         .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value));

  // Slave model. Each attempt stalls for stall_n cycles. In addition, the first
  // stuck[addr] attempts at an address never complete.
  logic [31:0] id_word, ts_word;
  int stall_n, stuck[2], run, att[2];

  always_comb begin
    avm_waitrequest = avm_read && ((att[avm_address] < stuck[avm_address]) || (run < stall_n));
    avm_readdata    = avm_address ? ts_word : id_word;
  end

  always @(posedge clock) begin
    if (start) begin
      run <= 0; att[0] <= 0; att[1] <= 0;
    end else if (avm_read) begin
      if (avm_waitrequest) run <= run + 1;
      else run <= 0;
    end else if (run != 0) begin
      att[avm_address] <= att[avm_address] + 1;
      run <= 0;
    end
  end

  // Bus monitor for the abort case.
  int rises0, hi0;
  bit saw1;
  logic prev_rd;
  always @(posedge clock) begin
    prev_rd <= avm_read;
    if (start) begin
      rises0 <= 0; hi0 <= 0; saw1 <= 0;
    end else begin
      if (avm_read && !avm_address) begin
        hi0 <= hi0 + 1;
        if (!prev_rd) rises0 <= rises0 + 1;
      end
      if (avm_read && avm_address) saw1 <= 1'b1;
    end
  end

  typedef struct {
    logic idok, tsok, terr;
    logic [31:0] idv, tsv;
    int lat;
  } exp_t;
  typedef struct {
    logic [31:0] id_w, ts_w;
    int stall, st_id, st_ts;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int lat;
    bit got;
    sb.push_back(v.e);
    id_word = v.id_w; ts_word = v.ts_w;
    stall_n = v.stall; stuck[0] = v.st_id; stuck[1] = v.st_ts;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    lat = 0; got = 0;
    while (!got && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (done) got = 1;
    end
    e = sb.pop_front();
    chk("done_seen", got, 1);
    chk("latency", lat, e.lat);
    chk("id_ok", id_ok, e.idok);
    chk("ts_ok", ts_ok, e.tsok);
    chk("timeout_err", timeout_err, e.terr);
    chk("id_value", id_value, e.idv);
    chk("ts_value", ts_value, e.tsv);
    @(posedge clock); #1;
    chk("done_one_cycle", done, 0);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    bit done_seen, found;
    vec_t v;
    vecs[0] = '{32'h0,        T,            0,  0, 0, '{1, 1, 0, 32'h0,        T,            3}};
    vecs[1] = '{32'h12345678, T,            0,  0, 0, '{0, 1, 0, 32'h12345678, T,            3}};
    vecs[2] = '{32'h0,        32'hDEADBEEF, 0,  0, 0, '{1, 0, 0, 32'h0,        32'hDEADBEEF, 3}};
    vecs[3] = '{32'h0,        T,            5,  0, 0, '{1, 1, 0, 32'h0,        T,            13}};
    vecs[4] = '{32'h0,        T,            15, 0, 0, '{1, 1, 0, 32'h0,        T,            33}};
    // ID stuck: 3 attempts of 16 cycles with 1-cycle gaps, then abort; values held
    vecs[5] = '{32'hA5A5A5A5, 32'h11111111, 0,  3, 0, '{0, 0, 1, 32'h0,        T,            50}};
    // First ID attempt stuck, TS needs its full 3 attempts (retry count reset)
    vecs[6] = '{32'h0,        T,            0,  1, 2, '{1, 1, 0, 32'h0,        T,            54}};

    reset_n = 1'b0; start = 1'b0;
    id_word = '0; ts_word = '0; stall_n = 0; stuck[0] = 0; stuck[1] = 0;
    #3;
    chk("rst_read", avm_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {id_ok, ts_ok, timeout_err}, 0);
    chk("rst_values", id_value | ts_value, 0);
    @(posedge clock); #1 reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      if (vecs[i].st_id > 2) begin
        chk("abort_id_attempts", rises0, 3);
        chk("abort_id_read_cycles", hi0, 48);
        chk("abort_no_ts_read", saw1, 0);
      end
    end

    // A second start in RD_TS is ignored, then reset is applied mid-read.
    id_word = 32'hCAFEF00D; ts_word = T; stall_n = 5; stuck[0] = 0; stuck[1] = 0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clock); #1;
      if (avm_read && avm_address) found = 1;
    end
    chk("reached_rd_ts", found, 1);
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    chk("restart_ignored_addr", {avm_read, avm_address}, 2'b11);
    chk("restart_ignored_id", id_value, 32'hCAFEF00D);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_read", avm_read, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_outs", {done, id_ok, ts_ok, timeout_err, avm_address}, 0);
    chk("async_rst_id", id_value, 0);
    chk("async_rst_ts", ts_value, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      if (done || busy) done_seen = 1;
    end
    chk("no_done_after_reset", done_seen, 0);

    v = vecs[0];
    run_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sysid_read_sequencer.md
SYSID_READ_SEQUENCER -- requirements
Module: sysid_read_sequencer

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000, the system ID value expected at word 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'd1485636471, the build timestamp expected at word 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of cycles of waitrequest per read attempt (range 1..255).
REQ-004 SHALL have parameter MAX_RETRIES, default 2, the number of extra attempts per word after a timeout (range 0..7).
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle request to begin a check sequence.
REQ-008 SHALL have port avm_address, output, 1 bit: the Avalon-MM word address (0 = ID, 1 = timestamp).
REQ-009 SHALL have port avm_read, output, 1 bit: the Avalon-MM read strobe.
REQ-010 SHALL have port avm_readdata, input, 32 bits: the Avalon-MM read data, valid in the cycle where avm_read=1 and avm_waitrequest=0.
REQ-011 SHALL have port avm_waitrequest, input, 1 bit: the slave stall signal.
REQ-012 SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-013 SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a sequence.
REQ-014 SHALL have port id_ok, output, 1 bit: the captured ID equals EXPECTED_ID.
REQ-015 SHALL have port ts_ok, output, 1 bit: the captured timestamp equals EXPECTED_TS.
REQ-016 SHALL have port timeout_err, output, 1 bit: retries for a word were exhausted.
REQ-017 SHALL have port id_value, output, 32 bits: the last captured ID word.
REQ-018 SHALL have port ts_value, output, 32 bits: the last captured timestamp word.

Function
REQ-019 SHALL implement the states IDLE, RD_ID, RD_TS, CHECK and FINISH.
REQ-020 SHALL move IDLE->RD_ID on start=1 and, on that edge, clear id_ok, ts_ok, timeout_err and the retry and timeout counters.
REQ-021 SHALL drive avm_read=1 and avm_address=0 in RD_ID, and avm_read=1 and avm_address=1 in RD_TS; avm_read=0 in all other states.
REQ-022 SHALL hold avm_address and avm_read stable while avm_waitrequest=1.
REQ-023 SHALL capture avm_readdata into id_value (RD_ID) or ts_value (RD_TS) in the cycle avm_waitrequest=0, and advance RD_ID->RD_TS or RD_TS->CHECK on the same edge.
REQ-024 SHALL let a read complete in the first cycle of a state when waitrequest=0, so the minimum sequence is start edge -> RD_ID 1 cycle -> RD_TS 1 cycle -> CHECK 1 cycle -> FINISH, with done high 3 cycles after the start edge.
REQ-025 SHALL increment an 8-bit timeout counter each cycle that a read state sees waitrequest=1; when the count reaches TIMEOUT_CYCLES it SHALL deassert avm_read for exactly one cycle, reset the counter, increment the retry count, and reissue the same word.
REQ-026 SHALL, on a timeout when the retry count already equals MAX_RETRIES, set timeout_err=1 and go directly to FINISH without reading further words.
REQ-027 SHALL reset the retry count to 0 when moving from RD_ID to RD_TS.
REQ-028 SHALL, in CHECK, register id_ok=(id_value==EXPECTED_ID) and ts_ok=(ts_value==EXPECTED_TS) using full 32-bit equality.
REQ-029 SHALL pulse done=1 for one cycle in FINISH and then return to IDLE.
REQ-030 SHALL keep busy=1 in every state except IDLE.
REQ-031 SHALL ignore start while busy=1; start in the FINISH cycle is also ignored.
REQ-032 SHALL hold status outputs and captured values in IDLE until the next accepted start.
REQ-033 SHALL leave id_ok, ts_ok and ts_value unchanged on a timeout abort, so they stay at their cleared or last values (0 after the clear).

Reset
REQ-034 SHALL, while reset_n=0 and regardless of clock, force state IDLE, avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout_err=0, id_value=0, ts_value=0 and all counters to 0.
REQ-035 SHALL, on reset assertion mid-read, drop avm_read immediately and drop any sequence in progress; no done pulse follows reset release.

Verification
REQ-036 SHALL cover: waitrequest=0 always, slave returns 0 then 1485636471, start pulse -> done 3 cycles later, id_ok=1, ts_ok=1, timeout_err=0.
REQ-037 SHALL cover: slave returns 0x12345678 at word 0 -> id_ok=0, ts_ok=1, id_value=0x12345678.
REQ-038 SHALL cover: waitrequest=1 for 5 cycles on each read -> no retry, correct capture, done 13 cycles after the start edge.
REQ-039 SHALL cover: waitrequest stuck at 1 with TIMEOUT_CYCLES=16 and MAX_RETRIES=2 -> 3 attempts at address 0, each separated by a 1-cycle read gap, then timeout_err=1, done pulse, and address 1 never issued.
REQ-040 SHALL cover: a second start during RD_TS is ignored, then reset_n low during RD_TS -> avm_read=0 and all outputs 0 asynchronously, no done pulse.
REQ-041 SHALL cover: waitrequest stuck during the first ID attempt only -> the retry succeeds, the RD_TS retry count starts at 0, and the final id_ok=1 and ts_ok=1.
